mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux/enable strobes and the 2-bit alu_op consumed directly by the ALU control stage (00 = add, 01 = subtract, 10 = decode from funct).
- Handles variable-latency memory through a ready handshake.

Parameters:
- MEM_HANDSHAKE, 1: when 1, memory states wait for mem_ready. When 0, mem_ready is ignored and treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26], taken from the instruction register
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2
- alu_op  out  2  to ALU control
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when decoding an unsupported opcode

Behaviour:
- Single clock. Reset is synchronous, active-high.
- While rst = 1:
  - state = FETCH (0) at the next edge.
  - Every output other than state is forced to 0 combinationally, so there are no spurious writes.
- Moore outputs are decoded from the registered state, except the ready-qualified strobes noted below.
- Any output not listed for a state is 0.
- State encodings, per-state outputs, and transitions (no wait state stays put unless noted):
  - FETCH = 0:
    - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
    - ir_write and pc_write = mem_ready.
    - Holds until mem_ready, then goes to DECODE.
  - DECODE = 1:
    - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precomputes branch target).
    - Next state by opcode:
      - 000000 -> EXEC
      - 100011 (lw) -> MEMADR
      - 101011 (sw) -> MEMADR
      - 000100 (beq) -> BRANCH
      - 000010 (j) -> JUMP
      - 001000 (addi) -> ADDIEX
      - any other opcode -> FETCH, with illegal_op = 1 this cycle.
  - MEMADR = 2:
    - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
    - Goes to MEMRD for lw, MEMWR for sw, using the opcode still held in the IR.
  - MEMRD = 3:
    - Outputs: mem_read = 1, i_or_d = 1.
    - Holds until mem_ready, then goes to MEMWB.
  - MEMWB = 4:
    - Outputs: reg_write = 1, reg_dst = 0, mem_to_reg = 1, instr_done = 1.
    - Goes to FETCH.
  - MEMWR = 5:
    - Outputs: mem_write = 1, i_or_d = 1.
    - instr_done = mem_ready.
    - Holds until mem_ready, then goes to FETCH.
  - EXEC = 6:
    - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
    - Goes to RWB.
  - RWB = 7:
    - Outputs: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1.
    - Goes to FETCH.
  - BRANCH = 8:
    - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, instr_done = 1.
    - Goes to FETCH.
  - JUMP = 9:
    - Outputs: pc_write = 1, pc_source = 10, instr_done = 1.
    - Goes to FETCH.
  - ADDIEX = 10:
    - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
    - Goes to ADDIWB.
  - ADDIWB = 11:
    - Outputs: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1.
    - Goes to FETCH.
  - Encodings 12-15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - R-type, sw, addi: 4 cycles
  - beq, j: 3 cycles
- Each memory wait cycle adds 1 cycle.
- In FETCH, mem_read stays asserted throughout the wait. ir_write and pc_write never assert without mem_ready.
- Reset mid-instruction (including during a memory wait) aborts the instruction. No write strobe asserts on the reset cycle or on the following FETCH cycle until mem_ready.
- MEM_HANDSHAKE = 0: FETCH, MEMRD and MEMWR each last exactly 1 cycle.
- opcode is sampled only in DECODE and MEMADR. Changes in any other state are ignored.

Test Plan:
- Reset: rst = 1 for 2 cycles with mem_ready = 1 -> all strobes 0 during reset; state = 0 after reset; first cycle out of reset has mem_read = 1, ir_write = 1, pc_write = 1.
- lw (opcode 100011), mem_ready = 1 -> state sequence 0,1,2,3,4,0; reg_write = 1 with mem_to_reg = 1 on cycle 5; instr_done pulses once; alu_op = 00 throughout.
- R-type (000000), then beq (000100) -> alu_op = 10 in state 6, then alu_op = 01 with pc_write_cond = 1 and pc_source = 01 in state 8; instr_done pulses at cycles 4 and 7.
- sw with mem_ready low 3 cycles in MEMWR -> state held at 5 for 4 cycles, mem_write = 1 throughout, instr_done only on the ready cycle.
- Illegal opcode 111111 -> DECODE returns to FETCH with illegal_op = 1 for exactly 1 cycle; no reg_write or mem_write.
- Reset asserted mid-MEMRD wait -> next state = 0, no reg_write; MEM_HANDSHAKE = 0 build: lw completes in 5 cycles with mem_ready tied to 0.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - control FSM <-> multicycle datapath signal bundle
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS main control FSM
// Moore decode of the registered state; memory strobes are qualified by mem_ready.
module mips_multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;
  logic   ready;

  assign ready     = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign bus.state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = FETCH;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = ready;
        bus.pc_write  = ready;
        state_d       = ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes PC + (imm << 2) so BRANCH can use ALUOut
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDIEX;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_d      = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = ready;
        state_d        = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = RWB;
      end
      RWB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
      end
      JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
      end
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = ADDIWB;
      end
      ADDIWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Reset gates every strobe so an aborted instruction cannot write anything
    if (rst) begin
      {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
       bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
       bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done,
       bus.illegal_op} = '0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - self-checking bench for mips_multicycle_control
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] outs;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;
  ent_t sbq[$];

  always #5 clk = ~clk;

  mips_multicycle_control_if dif();
  mips_multicycle_control_if dif2();

  mips_multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (.clk(clk), .rst(rst), .bus(dif.master));
  mips_multicycle_control #(.MEM_HANDSHAKE(1'b0)) dut2 (.clk(clk), .rst(rst2), .bus(dif2.master));

  // Bit layout: pc_write pc_write_cond i_or_d mem_read mem_write ir_write
  // mem_to_reg reg_dst reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2] instr_done illegal_op
  function automatic logic [17:0] outs1();
    return {dif.pc_write, dif.pc_write_cond, dif.i_or_d, dif.mem_read, dif.mem_write,
            dif.ir_write, dif.mem_to_reg, dif.reg_dst, dif.reg_write, dif.alu_src_a,
            dif.alu_src_b, dif.alu_op, dif.pc_source, dif.instr_done, dif.illegal_op};
  endfunction

  function automatic logic [17:0] outs2();
    return {dif2.pc_write, dif2.pc_write_cond, dif2.i_or_d, dif2.mem_read, dif2.mem_write,
            dif2.ir_write, dif2.mem_to_reg, dif2.reg_dst, dif2.reg_write, dif2.alu_src_a,
            dif2.alu_src_b, dif2.alu_op, dif2.pc_source, dif2.instr_done, dif2.illegal_op};
  endfunction

  function automatic logic [17:0] exp_outs(input logic r, input logic [3:0] st,
                                           input logic rdy, input logic [5:0] op);
    logic [17:0] o;
    o = '0;
    if (r) return o;
    case (st)
      4'd0:  begin o[14] = 1'b1; o[7:6] = 2'b01; o[17] = rdy; o[12] = rdy; end
      4'd1:  begin
        o[7:6] = 2'b11;
        o[0] = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      4'd2:  begin o[8] = 1'b1; o[7:6] = 2'b10; end
      4'd3:  begin o[14] = 1'b1; o[15] = 1'b1; end
      4'd4:  begin o[9] = 1'b1; o[11] = 1'b1; o[1] = 1'b1; end
      4'd5:  begin o[13] = 1'b1; o[15] = 1'b1; o[1] = rdy; end
      4'd6:  begin o[8] = 1'b1; o[5:4] = 2'b10; end
      4'd7:  begin o[9] = 1'b1; o[10] = 1'b1; o[1] = 1'b1; end
      4'd8:  begin o[8] = 1'b1; o[5:4] = 2'b01; o[16] = 1'b1; o[3:2] = 2'b01; o[1] = 1'b1; end
      4'd9:  begin o[17] = 1'b1; o[3:2] = 2'b10; o[1] = 1'b1; end
      4'd10: begin o[8] = 1'b1; o[7:6] = 2'b10; end
      4'd11: begin o[9] = 1'b1; o[1] = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st);
    ent_t e;
    e.rst = r; e.op = op; e.rdy = rdy; e.st = st;
    e.outs = exp_outs(r, st, rdy, op);
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    ent_t e;
    int n = 0;
    rst = 1'b1; dif.mem_ready = 1'b1; dif.opcode = OP_J;
    #1;
    checks++;
    if (outs1() !== 18'h0) begin
      errors++;
      $display("FAIL reset_strobes_first: outs=%b expected=%b", outs1(), 18'h0);
    end
    @(posedge clk); #1;
    push(1'b1, OP_J, 1'b1, 4'd0);
    push(1'b0, OP_J, 1'b1, 4'd0);
    push(1'b0, OP_J, 1'b1, 4'd1);
    push(1'b0, OP_BAD, 1'b1, 4'd9);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.rst; dif.opcode = e.op; dif.mem_ready = e.rdy;
      #1;
      checks++;
      if ({dif.state, outs1()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL reset cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif.state, outs1(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_lw();
    ent_t e;
    int n = 0, done_cnt = 0, alu_bad = 0;
    push(1'b0, OP_LW, 1'b1, 4'd0);
    push(1'b0, OP_LW, 1'b1, 4'd1);
    push(1'b0, OP_LW, 1'b1, 4'd2);
    push(1'b0, 6'h15, 1'b1, 4'd3);
    push(1'b0, 6'h2a, 1'b1, 4'd4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.rst; dif.opcode = e.op; dif.mem_ready = e.rdy;
      #1;
      done_cnt += int'(dif.instr_done);
      if (dif.alu_op != 2'b00) alu_bad++;
      checks++;
      if ({dif.state, outs1()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL lw cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif.state, outs1(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done_cnt !== 1 || alu_bad !== 0 || dif.state !== 4'd0) begin
      errors++;
      $display("FAIL lw_summary: done=%0d alu_bad=%0d state=%0d expected done=1 alu_bad=0 state=0",
               done_cnt, alu_bad, dif.state);
    end
  endtask

  task automatic test_rtype_beq();
    ent_t e;
    int n = 0;
    logic [31:0] done_at = '0;
    push(1'b0, OP_R,   1'b1, 4'd0);
    push(1'b0, OP_R,   1'b1, 4'd1);
    push(1'b0, OP_SW,  1'b1, 4'd6);
    push(1'b0, OP_LW,  1'b1, 4'd7);
    push(1'b0, OP_BEQ, 1'b1, 4'd0);
    push(1'b0, OP_BEQ, 1'b1, 4'd1);
    push(1'b0, OP_J,   1'b1, 4'd8);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.rst; dif.opcode = e.op; dif.mem_ready = e.rdy;
      #1;
      done_at[n] = dif.instr_done;
      checks++;
      if ({dif.state, outs1()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL rtype_beq cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif.state, outs1(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done_at !== 32'h0000_0048) begin
      errors++;
      $display("FAIL rtype_beq_done_cycles: mask=%h expected=%h", done_at, 32'h48);
    end
  endtask

  task automatic test_sw_wait();
    ent_t e;
    int n = 0, wr_cnt = 0;
    logic [31:0] done_at = '0;
    push(1'b0, OP_SW, 1'b1, 4'd0);
    push(1'b0, OP_SW, 1'b1, 4'd1);
    push(1'b0, OP_SW, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) push(1'b0, 6'($urandom_range(0, 63)), 1'b0, 4'd5);
    push(1'b0, OP_R, 1'b1, 4'd5);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.rst; dif.opcode = e.op; dif.mem_ready = e.rdy;
      #1;
      done_at[n] = dif.instr_done;
      wr_cnt += int'(dif.mem_write);
      checks++;
      if ({dif.state, outs1()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL sw_wait cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif.state, outs1(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done_at !== 32'h0000_0040 || wr_cnt !== 4 || dif.state !== 4'd0) begin
      errors++;
      $display("FAIL sw_wait_summary: done_mask=%h writes=%0d state=%0d expected done_mask=40 writes=4 state=0",
               done_at, wr_cnt, dif.state);
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    int n = 0, ill_cnt = 0, wr_cnt = 0;
    push(1'b0, OP_BAD, 1'b1, 4'd0);
    push(1'b0, OP_BAD, 1'b1, 4'd1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.rst; dif.opcode = e.op; dif.mem_ready = e.rdy;
      #1;
      ill_cnt += int'(dif.illegal_op);
      wr_cnt  += int'(dif.reg_write) + int'(dif.mem_write);
      checks++;
      if ({dif.state, outs1()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL illegal cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif.state, outs1(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (ill_cnt !== 1 || wr_cnt !== 0 || dif.state !== 4'd0) begin
      errors++;
      $display("FAIL illegal_summary: pulses=%0d writes=%0d state=%0d expected pulses=1 writes=0 state=0",
               ill_cnt, wr_cnt, dif.state);
    end
  endtask

  task automatic test_fetch_wait_addi();
    ent_t e;
    int n = 0;
    push(1'b0, OP_ADDI, 1'b0, 4'd0);
    push(1'b0, OP_ADDI, 1'b0, 4'd0);
    push(1'b0, OP_ADDI, 1'b1, 4'd0);
    push(1'b0, OP_ADDI, 1'b1, 4'd1);
    push(1'b0, OP_BEQ,  1'b0, 4'd10);
    push(1'b0, OP_J,    1'b0, 4'd11);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.rst; dif.opcode = e.op; dif.mem_ready = e.rdy;
      #1;
      checks++;
      if ({dif.state, outs1()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL fetch_wait_addi cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif.state, outs1(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset_mid_memrd();
    ent_t e;
    int n = 0, rw_cnt = 0;
    push(1'b0, OP_LW, 1'b1, 4'd0);
    push(1'b0, OP_LW, 1'b1, 4'd1);
    push(1'b0, OP_LW, 1'b1, 4'd2);
    push(1'b0, OP_LW, 1'b0, 4'd3);
    push(1'b0, OP_LW, 1'b0, 4'd3);
    push(1'b1, OP_LW, 1'b0, 4'd3);
    push(1'b0, OP_LW, 1'b0, 4'd0);
    push(1'b0, OP_J,  1'b1, 4'd0);
    push(1'b0, OP_J,  1'b1, 4'd1);
    push(1'b0, OP_LW, 1'b1, 4'd9);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.rst; dif.opcode = e.op; dif.mem_ready = e.rdy;
      #1;
      rw_cnt += int'(dif.reg_write);
      checks++;
      if ({dif.state, outs1()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif.state, outs1(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (rw_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid_reg_write: count=%0d expected=0", rw_cnt);
    end
  endtask

  task automatic test_no_handshake();
    ent_t e;
    int n = 0;
    logic [31:0] done_at = '0;
    push(1'b1, OP_LW, 1'b1, 4'd0);
    push(1'b0, OP_LW, 1'b1, 4'd0);
    push(1'b0, OP_LW, 1'b1, 4'd1);
    push(1'b0, OP_LW, 1'b1, 4'd2);
    push(1'b0, OP_R,  1'b1, 4'd3);
    push(1'b0, OP_R,  1'b1, 4'd4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst2 = e.rst; dif2.opcode = e.op; dif2.mem_ready = 1'b0;
      #1;
      done_at[n] = dif2.instr_done;
      checks++;
      if ({dif2.state, outs2()} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL no_handshake cyc%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 n, dif2.state, outs2(), e.st, e.outs);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done_at !== 32'h0000_0020 || dif2.state !== 4'd0) begin
      errors++;
      $display("FAIL no_handshake_latency: done_mask=%h state=%0d expected done_mask=20 state=0",
               done_at, dif2.state);
    end
  endtask

  initial begin
    rst2 = 1'b1;
    dif2.opcode = OP_LW;
    dif2.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_rtype_beq();
    test_sw_wait();
    test_illegal();
    test_fetch_wait_addi();
    test_reset_mid_memrd();
    test_no_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
